// File: rtl/score_keeper_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : score_keeper_pkg                                          |
// | Purpose  : Shared configuration for the score keeper: FSM state      |
// |            encoding and default parameter values.                    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package score_keeper_pkg;

   // Game-flow states of the score keeper
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_POINT = 3'd3,
      ST_OVER  = 3'd4
   } state_t;

   // Default parameter values
   localparam int c_WIN_SCORE_DEFAULT    = 11;
   localparam int c_SERVE_FRAMES_DEFAULT = 60;
   localparam int c_DEBOUNCE_DEFAULT     = 250000;

   // Score register width; 4 bits covers the legal 1..15 win range
   localparam int c_SCORE_W = 4;

endpackage : score_keeper_pkg
`default_nettype wire

// File: rtl/score_keeper_switch_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : Switch_Debounce                                           |
// | Purpose  : Two-flop synchroniser followed by a stability-count       |
// |            debouncer for a raw mechanical switch.                    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module Switch_Debounce
   import score_keeper_pkg::*;
#(
   parameter int p_DEBOUNCE = c_DEBOUNCE_DEFAULT
)(
   input  logic i_Clk,
   input  logic i_Rst_n,
   input  logic i_Sw,
   output logic o_Level
);

   // Counter holds 0 .. p_DEBOUNCE-1 consecutive "different" cycles
   localparam int                 c_CNT_W    = (p_DEBOUNCE > 1) ? $clog2(p_DEBOUNCE) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(p_DEBOUNCE - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

   logic               r_sync_meta;
   logic               r_sync;
   logic [c_CNT_W-1:0] r_stable_cnt;
   logic               r_level;

   // Bring the asynchronous switch into the clock domain
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_sync_meta <= 1'b0;
         r_sync      <= 1'b0;
      end else begin
         r_sync_meta <= i_Sw;
         r_sync      <= r_sync_meta;
      end
   end

   // Accept a new level once it has differed from the current one for p_DEBOUNCE cycles in a row
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_stable_cnt <= '0;
         r_level      <= 1'b0;
      end else if (r_sync == r_level) begin
         r_stable_cnt <= '0;
      end else if (r_stable_cnt == c_CNT_LAST) begin
         r_level      <= r_sync;
         r_stable_cnt <= '0;
      end else begin
         r_stable_cnt <= r_stable_cnt + c_CNT_ONE;
      end
   end

   assign o_Level = r_level;

endmodule : Switch_Debounce
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : score_keeper                                              |
// | Purpose  : Pong game controller: serve hold, point scoring, win      |
// |            detection and serve-switch handling.                      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module score_keeper
   import score_keeper_pkg::*;
#(
   parameter int p_WIN_SCORE    = c_WIN_SCORE_DEFAULT,
   parameter int p_SERVE_FRAMES = c_SERVE_FRAMES_DEFAULT,
   parameter int p_DEBOUNCE     = c_DEBOUNCE_DEFAULT
)(
   input  logic                 i_Clk,
   input  logic                 i_Rst_n,
   input  logic                 i_Frame,
   input  logic                 i_Ball_L_Out,
   input  logic                 i_Ball_R_Out,
   input  logic                 i_Serve_Sw,
   output logic                 o_Ball_Enable,
   output logic                 o_Ball_Recenter,
   output logic                 o_Serve_Dir,
   output logic [c_SCORE_W-1:0] o_Score_L,
   output logic [c_SCORE_W-1:0] o_Score_R,
   output logic                 o_Game_Over,
   output logic                 o_Winner
);

   localparam logic [c_SCORE_W-1:0] c_WIN       = c_SCORE_W'(p_WIN_SCORE);
   localparam logic [c_SCORE_W-1:0] c_SCORE_ONE = c_SCORE_W'(1);

   // Serve frame counter holds 0 .. p_SERVE_FRAMES-1
   localparam int                 c_FRM_W    = (p_SERVE_FRAMES > 1) ? $clog2(p_SERVE_FRAMES) : 1;
   localparam logic [c_FRM_W-1:0] c_FRM_LAST = c_FRM_W'(p_SERVE_FRAMES - 1);
   localparam logic [c_FRM_W-1:0] c_FRM_ONE  = c_FRM_W'(1);

   // The press detector stays disarmed until the debounced level has been low for
   // longer than the synchroniser plus debounce latency. A switch held through reset
   // therefore reaches the debounced level before arming and cannot start a game.
   localparam int                 c_ARM_CYCLES = p_DEBOUNCE + 4;
   localparam int                 c_ARM_W      = $clog2(c_ARM_CYCLES + 1);
   localparam logic [c_ARM_W-1:0] c_ARM_LAST   = c_ARM_W'(c_ARM_CYCLES - 1);
   localparam logic [c_ARM_W-1:0] c_ARM_ONE    = c_ARM_W'(1);

   logic                 w_level;
   logic                 r_level_q;
   logic                 r_armed;
   logic [c_ARM_W-1:0]   r_arm_cnt;
   logic                 w_serve_press;

   state_t               r_state;
   state_t               w_state_next;
   logic [c_SCORE_W-1:0] r_score_l;
   logic [c_SCORE_W-1:0] r_score_r;
   logic [c_SCORE_W-1:0] w_score_l_next;
   logic [c_SCORE_W-1:0] w_score_r_next;
   logic                 r_serve_dir;
   logic                 w_serve_dir_next;
   logic                 r_winner;
   logic                 w_winner_next;
   logic                 r_recenter;
   logic                 w_recenter_next;
   logic [c_FRM_W-1:0]   r_frame_cnt;
   logic [c_FRM_W-1:0]   w_frame_cnt_next;

   Switch_Debounce #(
      .p_DEBOUNCE (p_DEBOUNCE)
   ) u_serve_debounce (
      .i_Clk   (i_Clk),
      .i_Rst_n (i_Rst_n),
      .i_Sw    (i_Serve_Sw),
      .o_Level (w_level)
   );

   // Delay the debounced level for rising-edge detection
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_level_q <= 1'b0;
      end else begin
         r_level_q <= w_level;
      end
   end

   // Arm the press detector once the switch has been seen released for long enough
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_arm_cnt <= '0;
         r_armed   <= 1'b0;
      end else if (!r_armed) begin
         if (w_level) begin
            r_arm_cnt <= '0;
         end else if (r_arm_cnt == c_ARM_LAST) begin
            r_armed <= 1'b1;
         end else begin
            r_arm_cnt <= r_arm_cnt + c_ARM_ONE;
         end
      end
   end

   assign w_serve_press = w_level & ~r_level_q & r_armed;

   // State, score and strobe registers
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_state     <= ST_IDLE;
         r_score_l   <= '0;
         r_score_r   <= '0;
         r_serve_dir <= 1'b0;
         r_winner    <= 1'b0;
         r_recenter  <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_state     <= w_state_next;
         r_score_l   <= w_score_l_next;
         r_score_r   <= w_score_r_next;
         r_serve_dir <= w_serve_dir_next;
         r_winner    <= w_winner_next;
         r_recenter  <= w_recenter_next;
         r_frame_cnt <= w_frame_cnt_next;
      end
   end

   // Next-state and next-register logic; the frame counter is held at zero outside SERVE
   always_comb begin
      w_state_next     = r_state;
      w_score_l_next   = r_score_l;
      w_score_r_next   = r_score_r;
      w_serve_dir_next = r_serve_dir;
      w_winner_next    = r_winner;
      w_recenter_next  = 1'b0;
      w_frame_cnt_next = '0;

      case (r_state)
         ST_IDLE, ST_OVER: begin
            if (w_serve_press) begin
               w_score_l_next  = '0;
               w_score_r_next  = '0;
               w_winner_next   = 1'b0;
               w_recenter_next = 1'b1;
               w_state_next    = ST_SERVE;
            end
         end

         ST_SERVE: begin
            w_frame_cnt_next = r_frame_cnt;
            if (i_Frame) begin
               if (r_frame_cnt == c_FRM_LAST) begin
                  w_frame_cnt_next = '0;
                  w_state_next     = ST_PLAY;
               end else begin
                  w_frame_cnt_next = r_frame_cnt + c_FRM_ONE;
               end
            end
         end

         ST_PLAY: begin
            if (i_Frame) begin
               if (i_Ball_L_Out && !i_Ball_R_Out) begin
                  if (r_score_r != c_WIN) begin
                     w_score_r_next = r_score_r + c_SCORE_ONE;
                  end
                  w_serve_dir_next = 1'b0;
                  w_state_next     = ST_POINT;
               end else if (i_Ball_R_Out && !i_Ball_L_Out) begin
                  if (r_score_l != c_WIN) begin
                     w_score_l_next = r_score_l + c_SCORE_ONE;
                  end
                  w_serve_dir_next = 1'b1;
                  w_state_next     = ST_POINT;
               end else if (i_Ball_L_Out && i_Ball_R_Out) begin
                  w_state_next = ST_POINT;
               end
            end
         end

         ST_POINT: begin
            if ((r_score_l == c_WIN) || (r_score_r == c_WIN)) begin
               w_winner_next = (r_score_r == c_WIN);
               w_state_next  = ST_OVER;
            end else begin
               w_recenter_next = 1'b1;
               w_state_next    = ST_SERVE;
            end
         end

         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   assign o_Ball_Enable   = (r_state == ST_PLAY);
   assign o_Game_Over     = (r_state == ST_OVER);
   assign o_Ball_Recenter = r_recenter;
   assign o_Serve_Dir     = r_serve_dir;
   assign o_Score_L       = r_score_l;
   assign o_Score_R       = r_score_r;
   assign o_Winner        = r_winner;

endmodule : score_keeper
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_score_keeper                                           |
// | Purpose  : Self-checking bench for score_keeper with a game-level    |
// |            reference model and randomized play.                      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_score_keeper;

   localparam int c_WIN   = 11;
   localparam int c_SERVE = 60;
   localparam int c_DEB   = 8;

   logic       i_Clk        = 1'b0;
   logic       i_Rst_n      = 1'b0;
   logic       i_Frame      = 1'b0;
   logic       i_Ball_L_Out = 1'b0;
   logic       i_Ball_R_Out = 1'b0;
   logic       i_Serve_Sw   = 1'b0;
   logic       o_Ball_Enable;
   logic       o_Ball_Recenter;
   logic       o_Serve_Dir;
   logic [3:0] o_Score_L;
   logic [3:0] o_Score_R;
   logic       o_Game_Over;
   logic       o_Winner;

   score_keeper #(
      .p_WIN_SCORE    (c_WIN),
      .p_SERVE_FRAMES (c_SERVE),
      .p_DEBOUNCE     (c_DEB)
   ) dut (
      .i_Clk           (i_Clk),
      .i_Rst_n         (i_Rst_n),
      .i_Frame         (i_Frame),
      .i_Ball_L_Out    (i_Ball_L_Out),
      .i_Ball_R_Out    (i_Ball_R_Out),
      .i_Serve_Sw      (i_Serve_Sw),
      .o_Ball_Enable   (o_Ball_Enable),
      .o_Ball_Recenter (o_Ball_Recenter),
      .o_Serve_Dir     (o_Serve_Dir),
      .o_Score_L       (o_Score_L),
      .o_Score_R       (o_Score_R),
      .o_Game_Over     (o_Game_Over),
      .o_Winner        (o_Winner)
   );

   always #5 i_Clk = ~i_Clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Game-level model: waiting for serve, holding the ball, in play, or game over
   bit m_hold;
   bit m_play;
   bit m_over;
   int m_hold_cnt;
   int m_sl;
   int m_sr;
   bit m_dir;
   bit m_winner;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_Clk);
      #1;
   endtask

   task automatic model_reset();
      m_hold = 0; m_play = 0; m_over = 0;
      m_hold_cnt = 0; m_sl = 0; m_sr = 0;
      m_dir = 0; m_winner = 0;
   endtask

   task automatic check_all(input string tag);
      check_eq({tag, "_score_l"}, int'(o_Score_L), m_sl);
      check_eq({tag, "_score_r"}, int'(o_Score_R), m_sr);
      check_eq({tag, "_enable"}, int'(o_Ball_Enable), int'(m_play));
      check_eq({tag, "_over"}, int'(o_Game_Over), int'(m_over));
      check_eq({tag, "_dir"}, int'(o_Serve_Dir), int'(m_dir));
      if (m_over) check_eq({tag, "_winner"}, int'(o_Winner), int'(m_winner));
   endtask

   // Idle cycles with random out-of-bounds levels that must be ignored without a frame
   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         i_Ball_L_Out = 1'($urandom_range(0, 1));
         i_Ball_R_Out = 1'($urandom_range(0, 1));
         tick();
      end
      i_Ball_L_Out = 1'b0;
      i_Ball_R_Out = 1'b0;
      if (n > 0) check_all("gap");
   endtask

   // One frame strobe with the given out-of-bounds levels, then model update and checks
   task automatic do_frame(input bit l, input bit r);
      bit scored;
      scored = 0;
      i_Ball_L_Out = l;
      i_Ball_R_Out = r;
      i_Frame      = 1'b1;
      tick();
      i_Frame      = 1'b0;
      i_Ball_L_Out = 1'b0;
      i_Ball_R_Out = 1'b0;
      if (m_hold) begin
         m_hold_cnt++;
         if (m_hold_cnt == c_SERVE) begin
            m_hold = 0;
            m_play = 1;
         end
      end else if (m_play && (l || r)) begin
         if (l && !r) begin m_sr++; m_dir = 0; end
         if (r && !l) begin m_sl++; m_dir = 1; end
         m_play = 0;
         scored = 1;
      end
      check_all("frame");
      check_eq("frame_recenter", int'(o_Ball_Recenter), 0);
      if (scored) begin
         tick();
         if (m_sl == c_WIN || m_sr == c_WIN) begin
            m_over   = 1;
            m_winner = (m_sr == c_WIN);
            check_eq("point_recenter", int'(o_Ball_Recenter), 0);
         end else begin
            m_hold     = 1;
            m_hold_cnt = 0;
            check_eq("point_recenter", int'(o_Ball_Recenter), 1);
         end
         check_all("after_point");
      end
   endtask

   task automatic serve_hold();
      while (m_hold) begin
         gap($urandom_range(0, 2));
         do_frame(0, 0);
      end
   endtask

   // kind: 0 = left out, 1 = right out, 2 = both out
   task automatic play_point(input int kind);
      repeat ($urandom_range(0, 2)) begin
         gap($urandom_range(0, 2));
         do_frame(0, 0);
      end
      gap($urandom_range(0, 2));
      do_frame(kind != 1, kind != 0);
   endtask

   // Clean press of exactly the debounce length; counts recenter pulses in a fixed window
   task automatic do_press();
      int pulses;
      bit starts;
      pulses = 0;
      starts = !m_hold && !m_play;
      i_Serve_Sw = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (i == c_DEB) i_Serve_Sw = 1'b0;
         tick();
         if (o_Ball_Recenter) pulses++;
      end
      check_eq("press_pulses", pulses, int'(starts));
      if (starts) begin
         m_sl = 0; m_sr = 0; m_over = 0; m_winner = 0;
         m_hold = 1; m_hold_cnt = 0;
      end
      check_all("press");
   endtask

   // Bounces all shorter than the debounce length must not produce a press
   task automatic do_bounce();
      int pulses;
      pulses = 0;
      for (int b = 0; b < 5; b++) begin
         i_Serve_Sw = 1'b1;
         repeat ($urandom_range(1, c_DEB - 1)) begin
            tick();
            if (o_Ball_Recenter) pulses++;
         end
         i_Serve_Sw = 1'b0;
         repeat ($urandom_range(1, 3)) begin
            tick();
            if (o_Ball_Recenter) pulses++;
         end
      end
      repeat (15) begin
         tick();
         if (o_Ball_Recenter) pulses++;
      end
      check_eq("bounce_pulses", pulses, 0);
      check_all("bounce");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pulses;
      int points;
      model_reset();

      // Reset with the serve switch already held
      i_Serve_Sw = 1'b1;
      i_Rst_n    = 1'b0;
      repeat (3) tick();
      check_all("reset");
      check_eq("reset_recenter", int'(o_Ball_Recenter), 0);
      check_eq("reset_winner", int'(o_Winner), 0);
      i_Rst_n = 1'b1;
      pulses  = 0;
      repeat (40) begin
         tick();
         if (o_Ball_Recenter) pulses++;
      end
      check_eq("held_pulses", pulses, 0);
      check_all("held");
      i_Serve_Sw = 1'b0;
      repeat (40) tick();

      // Short bounces, then one clean press starts a game
      do_bounce();
      do_press();
      serve_hold();

      // Right edge out: left player scores, serve goes right
      play_point(1);
      check_eq("first_point_l", int'(o_Score_L), 1);
      serve_hold();

      // Both out: no score change, back to serve
      play_point(2);
      serve_hold();

      // Serve presses while playing or holding are ignored
      do_press();
      play_point(0);
      do_press();
      serve_hold();

      // Left player runs to the win
      while (!m_over) begin
         play_point(1);
         if (m_hold) serve_hold();
      end
      check_eq("win_score_l", int'(o_Score_L), c_WIN);
      check_eq("win_winner", int'(o_Winner), 0);

      // Frames and out-of-bounds in OVER change nothing
      for (int i = 0; i < 4; i++) begin
         gap($urandom_range(0, 2));
         do_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // New game, played out with random outcomes
      do_press();
      check_eq("new_game_l", int'(o_Score_L), 0);
      points = 0;
      while (!m_over && points < 40) begin
         if (m_hold) serve_hold();
         play_point($urandom_range(0, 9) < 2 ? 2 : int'($urandom_range(0, 1)));
         points++;
      end
      check_eq("random_game_over", int'(o_Game_Over), int'(m_over));

      // Reset mid-game, coincident with a scoring frame
      do_press();
      serve_hold();
      i_Frame      = 1'b1;
      i_Ball_L_Out = 1'b1;
      i_Rst_n      = 1'b0;
      #1;
      model_reset();
      check_all("midreset");
      tick();
      i_Frame      = 1'b0;
      i_Ball_L_Out = 1'b0;
      check_all("midreset_clk");
      i_Rst_n = 1'b1;
      repeat (30) tick();
      do_press();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_score_keeper
`default_nettype wire
